// File: rtl/vlog_sum_acc.sv
// Valid/ready accumulator: sums COUNT samples, presents a held result.
// Optional VLOG_SUM_ACC_SATURATE_EN clamps the total instead of wrapping.
module vlog_sum_acc #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [7:0]           out_count,
  output logic                 overflow,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic                 carry;
  logic                 last;
  logic                 take;

  assign sum_ext = {1'b0, acc}
                 + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_data};
  assign carry   = sum_ext[ACC_WIDTH];
  assign take    = in_valid && in_ready;
  assign last    = out_count == 8'(COUNT - 1);

  always_comb begin
    acc_nxt = sum_ext[ACC_WIDTH-1:0];
`ifdef VLOG_SUM_ACC_SATURATE_EN
    if (carry) acc_nxt = '1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= ACC;
            acc       <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ACC: begin
          if (take) begin
            acc       <= acc_nxt;
            out_count <= out_count + 8'd1;
            if (carry) overflow <= 1'b1;
            if (last) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= acc_nxt;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // start on the handshake edge skips IDLE entirely
            if (start) begin
              state     <= ACC;
              acc       <= '0;
              out_count <= '0;
              overflow  <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vlog_sum_acc.sv
// Directed bench for vlog_sum_acc: default instance plus a
// 9-bit/COUNT=3 instance for the overflow case.
module tb_vlog_sum_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        overflow;
  logic        busy;

  logic        start2;
  logic        in_valid2;
  logic        in_ready2;
  logic        out_valid2;
  logic [8:0]  out_sum2;
  logic [7:0]  out_count2;
  logic        overflow2;
  logic        busy2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vlog_sum_acc u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count),
    .overflow(overflow), .busy(busy)
  );

  vlog_sum_acc #(.WIDTH(8), .ACC_WIDTH(9), .COUNT(3)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(out_sum2), .out_count(out_count2),
    .overflow(overflow2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 0);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " out_sum"}, 32'(out_sum), 0);
    chk({tag, " out_count"}, 32'(out_count), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask

  logic [7:0] smp [4];
  logic [8:0] exp_ovf;

  initial begin
    smp[0] = 8'd7;
    smp[1] = 8'd15;
    smp[2] = 8'd5;
    smp[3] = 8'd2;
`ifdef VLOG_SUM_ACC_SATURATE_EN
    exp_ovf = 9'd511;
`else
    exp_ovf = 9'd8;
`endif
    rst_n = 1'b0; start = 0; in_valid = 0; in_data = 0;
    out_ready = 0; start2 = 0; in_valid2 = 0;
    tick();
    chk_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // in_valid ignored in IDLE
    in_valid = 1; in_data = 8'd99;
    tick();
    chk("idle ignore busy", 32'(busy), 0);
    chk("idle ignore count", 32'(out_count), 0);

    // basic block, in_valid held
    start = 1; in_valid = 0;
    tick();
    start = 0;
    chk("start in_ready", 32'(in_ready), 1);
    chk("start busy", 32'(busy), 1);
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = smp[i];
      tick();
      chk("basic out_valid", 32'(out_valid), (i == 3) ? 1 : 0);
    end
    in_valid = 0;
    chk("basic sum", 32'(out_sum), 29);
    chk("basic count", 32'(out_count), 4);
    chk("basic overflow", 32'(overflow), 0);
    chk("basic in_ready", 32'(in_ready), 0);

    // backpressure with noise on in_valid and start
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; in_data = 8'd50; start = i[1];
      tick();
      chk("bp out_valid", 32'(out_valid), 1);
      chk("bp sum", 32'(out_sum), 29);
      chk("bp in_ready", 32'(in_ready), 0);
      chk("bp count", 32'(out_count), 4);
    end
    in_valid = 0; start = 0; out_ready = 1;
    tick();
    out_ready = 0;
    chk("bp done out_valid", 32'(out_valid), 0);
    chk("bp done busy", 32'(busy), 0);
    chk("bp held sum", 32'(out_sum), 29);
    chk("bp held count", 32'(out_count), 4);

    // stalls between samples
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = smp[i];
      tick();
      in_valid = 0; in_data = 8'd200;
      chk("stall count", 32'(out_count), 32'(i + 1));
      if (i < 3) begin
        for (int j = 0; j < 2; j++) begin
          chk("stall in_ready", 32'(in_ready), 1);
          tick();
        end
        chk("stall hold count", 32'(out_count), 32'(i + 1));
      end
    end
    chk("stall out_valid", 32'(out_valid), 1);
    chk("stall sum", 32'(out_sum), 29);

    // back-to-back: start on the handshake edge
    out_ready = 1; start = 1;
    tick();
    out_ready = 0; start = 0;
    chk("b2b out_valid", 32'(out_valid), 0);
    chk("b2b busy", 32'(busy), 1);
    chk("b2b in_ready", 32'(in_ready), 1);
    chk("b2b count", 32'(out_count), 0);
    in_valid = 1; in_data = 8'd1;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 0;
    chk("b2b sum", 32'(out_sum), 4);
    chk("b2b overflow", 32'(overflow), 0);
    chk("b2b out_valid2", 32'(out_valid), 1);
    out_ready = 1;
    tick();
    out_ready = 0;

    // overflow on the 9-bit instance
    start2 = 1;
    tick();
    start2 = 0; in_valid2 = 1;
    in_data = 8'd255; tick();
    in_data = 8'd255; tick();
    chk("ovf mid overflow", 32'(overflow2), 0);
    in_data = 8'd10; tick();
    in_valid2 = 0;
    chk("ovf out_valid", 32'(out_valid2), 1);
    chk("ovf sum", 32'(out_sum2), 32'(exp_ovf));
    chk("ovf flag", 32'(overflow2), 1);
    chk("ovf count", 32'(out_count2), 3);
    chk("ovf main idle", 32'(busy), 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("ovf held flag", 32'(overflow2), 1);

    // reset mid-block
    start = 1;
    tick();
    start = 0; in_valid = 1;
    in_data = 8'd3; tick();
    in_data = 8'd4; tick();
    in_valid = 0;
    chk("mid count", 32'(out_count), 2);
    rst_n = 1'b0;
    #1;
    chk_zero("async rst");
    tick();
    rst_n = 1'b1;
    in_valid = 1; in_data = 8'd9;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post rst out_valid", 32'(out_valid), 0);
      chk("post rst in_ready", 32'(in_ready), 0);
    end
    in_valid = 0;
    start = 1;
    tick();
    start = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = smp[i];
      tick();
    end
    in_valid = 0;
    chk("fresh out_valid", 32'(out_valid), 1);
    chk("fresh sum", 32'(out_sum), 29);
    chk("fresh count", 32'(out_count), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
